// File: rtl/sram_rw_ctrl_if.sv
// Request and read-response handshake bundle between a requester and sram_rw_ctrl.
interface sram_rw_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wmode;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_wmode, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wmode, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_rw_ctrl.sv
// Single-port SRAM access controller: passes accepted requests straight to the SRAM and
// buffers read data in a 2-entry response FIFO with fixed two-cycle read latency.
module sram_rw_ctrl_chk (
  input logic       clock,
  input logic       reset_n,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);
  // Admission control must make a push into a full FIFO without a pop impossible.
  no_overflow_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (count == 2'd2)));
endmodule

module sram_rw_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_rw_ctrl_if.slave     bus,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);
  logic              run_r;
  logic              inflight_r;
  logic [1:0]        count_r;
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [DATA_W-1:0] fifo_r [0:1];
  logic [15:0]       rd_cnt_r;
  logic [15:0]       wr_cnt_r;

  logic [2:0]        occ_s;
  logic              pop_s;
  logic              push_s;
  logic              ready_s;
  logic              accept_s;

  // Admission: a slot must be free counting the read still in flight, unless the head leaves now.
  always_comb begin
    occ_s    = {1'b0, count_r} + {2'b00, inflight_r};
    pop_s    = (count_r != 2'd0) && bus.resp_ready;
    push_s   = inflight_r;
    ready_s  = run_r && ((occ_s < 3'd2) || pop_s);
    accept_s = bus.req_valid && ready_s;
  end

  assign bus.req_ready  = ready_s;
  assign bus.resp_valid = (count_r != 2'd0);
  assign bus.resp_rdata = fifo_r[rd_ptr_r];
  assign mem_en         = accept_s;
  assign mem_wmode      = bus.req_wmode;
  assign mem_addr       = bus.req_addr;
  assign mem_wdata      = bus.req_wdata;
  assign rd_cnt         = rd_cnt_r;
  assign wr_cnt         = wr_cnt_r;

  // Inflight tracking, response FIFO and saturating activity counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_r      <= 1'b0;
      inflight_r <= 1'b0;
      count_r    <= 2'd0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      fifo_r[0]  <= {DATA_W{1'b0}};
      fifo_r[1]  <= {DATA_W{1'b0}};
      rd_cnt_r   <= 16'h0000;
      wr_cnt_r   <= 16'h0000;
    end else begin
      run_r      <= 1'b1;
      inflight_r <= accept_s && !bus.req_wmode;
      if (push_s) begin
        fifo_r[wr_ptr_r] <= mem_rdata;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (pop_s && (rd_cnt_r != 16'hFFFF)) begin
        rd_cnt_r <= rd_cnt_r + 16'd1;
      end
      if (accept_s && bus.req_wmode && (wr_cnt_r != 16'hFFFF)) begin
        wr_cnt_r <= wr_cnt_r + 16'd1;
      end
    end
  end

  sram_rw_ctrl_chk u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .count   (count_r)
  );
endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed bench for sram_rw_ctrl with a behavioural single-port SRAM (one-cycle read latency).
module tb_sram_rw_ctrl;
  logic        clock;
  logic        reset_n;
  logic        mem_en;
  logic        mem_wmode;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [63:0] sram [0:255];
  int          vectors;
  int          miscompares;
  int          en_pulses;
  int          en_base;

  sram_rw_ctrl_if #(.ADDR_W(8), .DATA_W(64)) bus ();

  sram_rw_ctrl #(.ADDR_W(8), .DATA_W(64)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_wmode (mem_wmode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      en_pulses <= en_pulses + 1;
      if (mem_wmode) sram[mem_addr] <= mem_wdata;
      else           mem_rdata      <= sram[mem_addr];
    end
  end

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [7:0] a, input logic [63:0] d);
    bus.req_valid = v;
    bus.req_wmode = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  initial begin
    vectors = 0; miscompares = 0; en_pulses = 0;
    reset_n = 1'b0;
    mem_rdata = 64'd0;
    bus.resp_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 64'd0);

    // Reset state, with a request offered to prove it is ignored.
    @(negedge clock);
    drive(1'b1, 1'b1, 8'h01, 64'h1);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_rd_cnt", rd_cnt, 16'h0);
    chk("rst_wr_cnt", wr_cnt, 16'h0);
    drive(1'b0, 1'b0, 8'h00, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("ready_before_edge", bus.req_ready, 1'b0);
    @(negedge clock);
    chk("ready_after_edge", bus.req_ready, 1'b1);

    // Write 0x12 then read it back with resp_ready high.
    bus.resp_ready = 1'b1;
    en_base = en_pulses;
    drive(1'b1, 1'b1, 8'h12, 64'hDEADBEEF_00000001);
    #1;
    chk("wr_mem_en", mem_en, 1'b1);
    chk("wr_mem_wmode", mem_wmode, 1'b1);
    chk("wr_mem_addr", mem_addr, 8'h12);
    chk("wr_mem_wdata", mem_wdata, 64'hDEADBEEF_00000001);
    @(negedge clock);
    drive(1'b1, 1'b0, 8'h12, 64'd0);
    #1;
    chk("rd_mem_en", mem_en, 1'b1);
    chk("rd_mem_wmode", mem_wmode, 1'b0);
    @(negedge clock);
    drive(1'b0, 1'b0, 8'h00, 64'd0);
    #1;
    chk("rd_n1_resp_valid", bus.resp_valid, 1'b0);
    chk("rd_n1_wr_cnt", wr_cnt, 16'd1);
    @(negedge clock);
    chk("rd_n2_resp_valid", bus.resp_valid, 1'b1);
    chk("rd_n2_rdata", bus.resp_rdata, 64'hDEADBEEF_00000001);
    @(negedge clock);
    chk("rd_n3_resp_valid", bus.resp_valid, 1'b0);
    chk("rd_cnt_1", rd_cnt, 16'd1);
    chk("wr_cnt_1", wr_cnt, 16'd1);
    chk("mem_en_pulses", 64'(en_pulses - en_base), 64'd2);

    // Fill addresses 0..7, then stream eight back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'(i), pat(i));
      @(negedge clock);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 1'b0, 8'(i), 64'd0);
      else       drive(1'b0, 1'b0, 8'h00, 64'd0);
      #1;
      if (i < 8) chk($sformatf("stream_ready_%0d", i), bus.req_ready, 1'b1);
      if (i >= 2) begin
        chk($sformatf("stream_valid_%0d", i - 2), bus.resp_valid, 1'b1);
        chk($sformatf("stream_data_%0d", i - 2), bus.resp_rdata, pat(i - 2));
      end
      @(negedge clock);
    end
    chk("stream_drained", bus.resp_valid, 1'b0);
    chk("stream_rd_cnt", rd_cnt, 16'd9);
    chk("stream_wr_cnt", wr_cnt, 16'd9);

    // Backpressure: three reads offered with resp_ready low.
    bus.resp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 64'd0);
    #1;
    chk("bp_ready_0", bus.req_ready, 1'b1);
    @(negedge clock);
    drive(1'b1, 1'b0, 8'h01, 64'd0);
    #1;
    chk("bp_ready_1", bus.req_ready, 1'b1);
    @(negedge clock);
    drive(1'b1, 1'b0, 8'h02, 64'd0);
    #1;
    chk("bp_ready_2", bus.req_ready, 1'b0);
    chk("bp_mem_en_2", mem_en, 1'b0);
    @(negedge clock);
    chk("bp_full_ready", bus.req_ready, 1'b0);
    chk("bp_count", dut.count_r, 2'd2);
    chk("bp_head", bus.resp_rdata, pat(0));
    @(negedge clock);
    chk("bp_head_stable", bus.resp_rdata, pat(0));
    chk("bp_still_blocked", bus.req_ready, 1'b0);
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready, 1'b1);
    chk("bp_release_mem_en", mem_en, 1'b1);
    @(negedge clock);
    drive(1'b0, 1'b0, 8'h00, 64'd0);
    #1;
    chk("bp_data_1", bus.resp_rdata, pat(1));
    @(negedge clock);
    chk("bp_data_2", bus.resp_rdata, pat(2));
    chk("bp_valid_2", bus.resp_valid, 1'b1);
    @(negedge clock);
    chk("bp_drained", bus.resp_valid, 1'b0);
    chk("bp_rd_cnt", rd_cnt, 16'd12);

    // Reset while a read of 0x05 is in flight.
    drive(1'b1, 1'b0, 8'h05, 64'd0);
    @(negedge clock);
    drive(1'b0, 1'b0, 8'h00, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_inflight", dut.inflight_r, 1'b0);
    chk("mid_rst_ready", bus.req_ready, 1'b0);
    chk("mid_rst_rd_cnt", rd_cnt, 16'h0);
    chk("mid_rst_wr_cnt", wr_cnt, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_valid", bus.resp_valid, 1'b0);
    chk("post_rst_count", dut.count_r, 2'd0);
    chk("post_rst_ready", bus.req_ready, 1'b1);
    @(negedge clock);
    chk("post_rst_no_stale", bus.resp_valid, 1'b0);

    // Read-after-write at the top address.
    drive(1'b1, 1'b1, 8'hFF, 64'h0101_0101_0101_0101);
    @(negedge clock);
    drive(1'b1, 1'b1, 8'hFF, 64'hFEED_FACE_CAFE_F00D);
    #1;
    chk("raw_mem_addr", mem_addr, 8'hFF);
    @(negedge clock);
    drive(1'b1, 1'b0, 8'hFF, 64'd0);
    @(negedge clock);
    drive(1'b0, 1'b0, 8'h00, 64'd0);
    @(negedge clock);
    chk("raw_valid", bus.resp_valid, 1'b1);
    chk("raw_data", bus.resp_rdata, 64'hFEED_FACE_CAFE_F00D);
    @(negedge clock);
    chk("raw_wr_cnt", wr_cnt, 16'd2);
    chk("raw_rd_cnt", rd_cnt, 16'd1);

    // Drive wr_cnt to 16'hFFFE with real writes, then three more must saturate.
    drive(1'b1, 1'b1, 8'h33, 64'h33);
    repeat (65532) @(negedge clock);
    drive(1'b0, 1'b0, 8'h00, 64'd0);
    #1;
    chk("sat_fffe", wr_cnt, 16'hFFFE);
    @(negedge clock);
    drive(1'b1, 1'b1, 8'h34, 64'h34);
    repeat (3) @(negedge clock);
    drive(1'b0, 1'b0, 8'h00, 64'd0);
    #1;
    chk("sat_ffff", wr_cnt, 16'hFFFF);
    @(negedge clock);
    chk("sat_hold", wr_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_rw_ctrl.md
SRAM_RW_CTRL -- requirements
Module: sram_rw_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SRAM address width (256 entries).
REQ-002 Parameter DATA_W, default 64, SRAM data width.
REQ-003 The block SHALL have exactly these ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  requester presents an access.
- req_ready  out  1  controller accepts the access this cycle.
- req_wmode  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  access address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the read data.
- resp_rdata  out  DATA_W  read data.
- mem_en  out  1  SRAM port enable.
- mem_wmode  out  1  SRAM write mode.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable.
- rd_cnt  out  16  completed reads (popped responses), saturating.
- wr_cnt  out  16  issued writes, saturating.

Function
REQ-004 Accept = req_valid && req_ready; request fields SHALL be held stable by the requester while req_valid && !req_ready.
REQ-005 mem_en SHALL equal accept combinationally; mem_wmode, mem_addr and mem_wdata SHALL be req_wmode, req_addr and req_wdata passed straight through.
REQ-006 An accepted read SHALL set the inflight flag for exactly the next cycle; in that cycle mem_rdata SHALL be pushed into a 2-entry response FIFO.
REQ-007 Read latency SHALL be fixed: read accepted in cycle N gives resp_valid in cycle N+2 if earlier responses have drained.
REQ-008 resp_valid SHALL be (FIFO count != 0); resp_rdata SHALL be the FIFO head and SHALL stay stable while resp_valid && !resp_ready.
REQ-009 pop = resp_valid && resp_ready; push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-010 req_ready SHALL be 1 when (count + inflight) < 2 or pop is 1. It SHALL NOT depend on req_valid, req_wmode or req_addr. The combinational path resp_ready -> req_ready is intentional.
REQ-011 Writes SHALL generate no response and SHALL never enter the FIFO. They SHALL obey the same req_ready rule, so ordering stays strict.
REQ-012 With resp_ready held at 1, back-to-back reads SHALL sustain one accept per cycle.
REQ-013 A read following a write to the same address in the next cycle SHALL return the newly written data.
REQ-014 The FIFO SHALL never overflow; a push when count=2 without pop is unreachable and SHALL be flagged by an assertion.
REQ-015 rd_cnt SHALL increment on pop and wr_cnt SHALL increment on write accept. Both SHALL saturate at 16'hFFFF.

Reset
REQ-016 While reset_n=0 the outputs SHALL be: req_ready=0, mem_en=0, resp_valid=0, count=0, inflight=0, rd_cnt=0, wr_cnt=0. These values SHALL take effect immediately, without waiting for clock.
REQ-017 Reset during an in-flight read SHALL discard that read; no response SHALL appear after reset_n returns to 1.
REQ-018 req_ready SHALL become 1 on the first clock edge after reset_n deasserts.

Verification
REQ-019 Write 0x12 <- 64'hDEADBEEF_00000001, then read 0x12 with resp_ready=1 -> mem_en pulses twice, resp_valid exactly 2 cycles after the read accept, resp_rdata=64'hDEADBEEF_00000001, rd_cnt=1, wr_cnt=1.
REQ-020 Eight consecutive reads of addresses 0..7 with resp_ready=1 -> eight accepts in eight cycles, responses in address order, no bubble.
REQ-021 resp_ready=0 with three reads offered -> two accepted, req_ready=0 with count=2, head data stable. Raising resp_ready -> third read accepted in the same cycle as the first pop, order preserved.
REQ-022 Read 0x05 accepted, then reset_n=0 in the next cycle -> resp_valid=0, count=0 after release, no stale response, counters 0.
REQ-023 Write to 0xFF, then read 0xFF on the immediately following cycle -> new data returned (address wrap-edge and read-after-write).
REQ-024 Force wr_cnt to 16'hFFFE and issue 3 writes -> wr_cnt holds at 16'hFFFF.
